// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera capture stage.
package cam_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_LINE_W = 10;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VS  = 3'd1,
    WAIT_ACT = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4
  } cam_state_e;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; a push while full with no pop is dropped.
module byte_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  push,
  input  logic  pop,
  input  byte_t din,
  output byte_t head,
  output logic  empty,
  output logic  full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  byte_t       mem_r [DEPTH];
  logic        empty_s;
  logic        full_s;
  logic        do_pop_s;
  logic        do_push_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  // A pop frees the slot the same-cycle push lands in, so full+pop+push is legal.
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);

  // Pointer update; flush wins over any same-cycle traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Head is forced to zero while empty so stale entries never leak out.
  always_comb begin
    if (empty_s) head = 8'h00;
    else         head = mem_r[rd_ptr_r[AW-1:0]];
  end

  assign empty = empty_s;
  assign full  = full_s;

endmodule

// File: rtl/cam_capture.sv
// Single-frame capture from an asynchronous 8-bit camera port into a byte FIFO.
module cam_capture
  import cam_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  input  logic              rd_en,
  output logic [7:0]        cam_data,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [LINE_W-1:0] line_cnt
);

  logic       pclk_s1_r, pclk_s2_r, pclk_s3_r;
  logic       vs_s1_r, vs_s2_r, vs_s3_r;
  logic       href_s1_r, href_s2_r, href_s3_r;
  byte_t      d_s1_r, d_s2_r;
  logic       pclk_rise_s, vs_rise_s, vs_fall_s, href_fall_s;
  cam_state_e state_r, state_s;
  logic       flush_s, push_s;
  logic       fifo_empty_s, fifo_full_s;
  byte_t      fifo_head_s;
  logic       overflow_r;
  logic [LINE_W-1:0] line_cnt_r;

  // Two-flop synchronisers plus a third stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {pclk_s1_r, pclk_s2_r, pclk_s3_r} <= 3'b000;
      {vs_s1_r, vs_s2_r, vs_s3_r}       <= 3'b000;
      {href_s1_r, href_s2_r, href_s3_r} <= 3'b000;
      d_s1_r <= 8'h00;
      d_s2_r <= 8'h00;
    end else begin
      {pclk_s1_r, pclk_s2_r, pclk_s3_r} <= {cam_pclk, pclk_s1_r, pclk_s2_r};
      {vs_s1_r, vs_s2_r, vs_s3_r}       <= {cam_vsync, vs_s1_r, vs_s2_r};
      {href_s1_r, href_s2_r, href_s3_r} <= {cam_href, href_s1_r, href_s2_r};
      d_s1_r <= cam_d;
      d_s2_r <= d_s1_r;
    end
  end

  assign pclk_rise_s = pclk_s2_r & ~pclk_s3_r;
  assign vs_rise_s   = vs_s2_r & ~vs_s3_r;
  assign vs_fall_s   = ~vs_s2_r & vs_s3_r;
  assign href_fall_s = ~href_s2_r & href_s3_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next state, flush on arm acceptance, pixel push during CAPTURE only.
  always_comb begin
    state_s = state_r;
    flush_s = 1'b0;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (arm) begin
          state_s = WAIT_VS;
          flush_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_VS: begin
        if (vs_rise_s) state_s = WAIT_ACT;
        else           state_s = WAIT_VS;
      end
      WAIT_ACT: begin
        if (vs_fall_s) state_s = CAPTURE;
        else           state_s = WAIT_ACT;
      end
      CAPTURE: begin
        push_s = pclk_rise_s & href_s2_r;
        if (vs_rise_s) state_s = DONE;
        else           state_s = CAPTURE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Saturating line counter and sticky drop flag, both cleared on arm acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_cnt_r <= {LINE_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush_s) begin
      line_cnt_r <= {LINE_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if ((state_r == CAPTURE) && href_fall_s && (line_cnt_r != {LINE_W{1'b1}}))
        line_cnt_r <= line_cnt_r + {{(LINE_W-1){1'b0}}, 1'b1};
      if (push_s && fifo_full_s && !rd_en)
        overflow_r <= 1'b1;
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_s),
    .push  (push_s),
    .pop   (rd_en),
    .din   (d_s2_r),
    .head  (fifo_head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign cam_data   = fifo_head_s;
  assign data_valid = ~fifo_empty_s;
  assign busy       = (state_r != IDLE);
  assign frame_done = (state_r == DONE);
  assign overflow   = overflow_r;
  assign line_cnt   = line_cnt_r;

endmodule
